cnn_div_seq_23s_14s: RTL and testbench
======================================

# cnn_div_seq_23s_14s

Sequential signed divider: 23-bit signed dividend / 14-bit signed divisor, 9-bit signed saturated quotient plus 14-bit signed remainder. It inverts the 9s×14s→23s product path of the CNN datapath and is used for requantization/normalization stages in conv/pool layers. Radix-2 restoring algorithm, one quotient bit per cycle, valid/ready handshakes on both sides.

## Interface
- DIVIDEND_WIDTH, 23, signed dividend width
- DIVISOR_WIDTH, 14, signed divisor width
- QUOTIENT_WIDTH, 9, signed saturated quotient width
- ap_clk  in  1  sole clock, rising edge
- ap_rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- dividend  in  DIVIDEND_WIDTH  signed numerator
- divisor  in  DIVISOR_WIDTH  signed denominator
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  QUOTIENT_WIDTH  signed, truncated toward zero, saturated
- remainder  out  DIVISOR_WIDTH  signed, sign of dividend
- ovf  out  1  quotient was saturated (nonzero divisor)
- dbz  out  1  divisor was zero

## Operation
- FSM states: IDLE, CALC, DONE. Reset → IDLE.
- IDLE: in_ready=1. On in_valid: latch |dividend| (23-bit unsigned, -2^22 → 2^22), |divisor| (14-bit unsigned, -8192 → 8192), sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend).
  - divisor==0 → DONE directly: dbz=1, ovf=0, remainder=0; quotient = 255 if dividend>0, -256 if dividend<0, 0 if dividend==0.
  - else → CALC, bit counter = DIVIDEND_WIDTH-1.
- CALC: per cycle, partial remainder (DIVISOR_WIDTH+1 bits) = {rem, next dividend MSB}; if ≥ |divisor| subtract and shift in 1, else shift in 0. Counter decrements; after counter==0 iteration → DONE. Exactly DIVIDEND_WIDTH CALC cycles.
- DONE entry: apply signs to 23-bit unsigned quotient; clip to [-2^(QW-1), 2^(QW-1)-1] = [-256, 255]; ovf=1 iff clipped. Remainder = ±rem per sign_r, never saturated (|rem| ≤ 8191 fits).
- DONE: out_valid=1; outputs stable while out_ready=0. On out_ready → IDLE.
- in_ready=0 in CALC and DONE; in_valid ignored there.
- Truncation toward zero in all cases (C semantics): dividend = quotient_unsat·divisor + remainder.

## Timing
- Reset values: in_ready=0 during reset cycle, 1 the cycle after; out_valid=0, quotient=0, remainder=0, ovf=0, dbz=0.
- Accept at edge 0 → CALC edges 1..23 → out_valid high from cycle after edge 23 (latency 24 cycles, accept edge to out_valid visible).
- Divisor zero: out_valid high cycle after accept edge (latency 1).
- Result handshake at edge n → in_ready=1 from cycle after n; minimum issue interval 25 cycles (no accept in DONE, even if out_ready simultaneous).
- ap_rst at any state (incl. mid-CALC, DONE with pending result): next cycle IDLE, out_valid=0, result dropped; no partial result emitted.
- All outputs registered; no combinational path input → output except none (in_ready derives from state only).

## Structure
- Package cnn_div_pkg: width constants (23/14/9), derived QMAX=255, QMIN=-256, state enum {IDLE, CALC, DONE}, counter width clog2(DIVIDEND_WIDTH).
- Sub-module cnn_div_seq_23s_14s_sat: combinational sign-apply + clip of 23-bit magnitude → QUOTIENT_WIDTH quotient and ovf; top holds FSM, counter, shift/subtract datapath.

## Test plan
- 1000 / 7 → quotient=142, remainder=6, ovf=0, dbz=0, out_valid exactly 24 cycles after accept.
- -1000 / 7 → -142, rem -6; 1000 / -7 → -142, rem 6; -2048 / 8 → -256, ovf=0 (exact lower bound).
- 100000 / 3 → quotient=255, ovf=1, rem=1; -4194304 / -8192 → 255, ovf=1, rem=0; 4194303 / -1 → -256, ovf=1.
- 5 / 0 → 255, dbz=1, rem=0 after 1 cycle; -5 / 0 → -256, dbz=1; 0 / 0 → 0, dbz=1.
- Backpressure: out_ready low 10 cycles in DONE → outputs stable, in_ready=0, in_valid pulses ignored; release → in_ready next cycle.
- ap_rst asserted 10 cycles into CALC → IDLE next cycle, out_valid never asserted; following 9 / 2 → 4, rem 1.

Source files
------------

// File: rtl/cnn_div_pkg.sv
// Shared constants and types for the sequential signed divider.
// Provides operand/result widths, the quotient clip limits (as signed
// results and as unsigned magnitude thresholds), the FSM state type and
// the iteration counter width.
package cnn_div_pkg;

  localparam int DIVIDEND_WIDTH = 23;
  localparam int DIVISOR_WIDTH  = 14;
  localparam int QUOTIENT_WIDTH = 9;

  localparam int QMAX_INT = 2 ** (QUOTIENT_WIDTH - 1) - 1;
  localparam int QMIN_INT = -(2 ** (QUOTIENT_WIDTH - 1));

  localparam logic signed [QUOTIENT_WIDTH-1:0] QMAX = QUOTIENT_WIDTH'(QMAX_INT);
  localparam logic signed [QUOTIENT_WIDTH-1:0] QMIN = QUOTIENT_WIDTH'(QMIN_INT);

  // Largest quotient magnitudes that still fit once the sign is applied.
  localparam logic [DIVIDEND_WIDTH-1:0] POS_MAG_LIM = DIVIDEND_WIDTH'(QMAX_INT);
  localparam logic [DIVIDEND_WIDTH-1:0] NEG_MAG_LIM = DIVIDEND_WIDTH'(-QMIN_INT);

  localparam int CNT_WIDTH = $clog2(DIVIDEND_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(DIVIDEND_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/cnn_div_seq_23s_14s_sat.sv
// Sign-apply and clip stage for the divider quotient.
// Ports:
//   mag  - unsigned quotient magnitude from the restoring loop
//   neg  - quotient sign (1 = negative)
//   q    - signed quotient clipped to [QMIN, QMAX]
//   ovf  - high when the clip changed the value
module cnn_div_seq_23s_14s_sat
  import cnn_div_pkg::*;
(
  input  logic [DIVIDEND_WIDTH-1:0]        mag,
  input  logic                             neg,
  output logic signed [QUOTIENT_WIDTH-1:0] q,
  output logic                             ovf
);

  // The negative range reaches one further than the positive range, so a
  // magnitude of exactly 256 becomes -256 without being flagged.
  always_comb begin
    q   = '0;
    ovf = 1'b0;
    if (neg) begin
      if (mag > NEG_MAG_LIM) begin
        q   = QMIN;
        ovf = 1'b1;
      end else begin
        q = -mag[QUOTIENT_WIDTH-1:0];
      end
    end else begin
      if (mag > POS_MAG_LIM) begin
        q   = QMAX;
        ovf = 1'b1;
      end else begin
        q = mag[QUOTIENT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/cnn_div_seq_23s_14s.sv
// Sequential signed divider: 23-bit signed dividend / 14-bit signed divisor,
// radix-2 restoring, one quotient bit per cycle.
// Ports:
//   ap_clk, ap_rst          - clock and synchronous active-high reset
//   in_valid/in_ready       - operand handshake (dividend, divisor)
//   out_valid/out_ready     - result handshake
//   quotient                - signed, truncated toward zero, saturated
//   remainder               - signed, carries the dividend's sign
//   ovf                     - quotient was clipped (nonzero divisor)
//   dbz                     - divisor was zero
module cnn_div_seq_23s_14s
  import cnn_div_pkg::*;
(
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [DIVIDEND_WIDTH-1:0] dividend,
  input  logic signed [DIVISOR_WIDTH-1:0]  divisor,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [QUOTIENT_WIDTH-1:0] quotient,
  output logic signed [DIVISOR_WIDTH-1:0]  remainder,
  output logic                             ovf,
  output logic                             dbz
);

  state_t                    state;
  logic [CNT_WIDTH-1:0]      cnt;
  logic [DIVIDEND_WIDTH-1:0] dvd;
  logic [DIVISOR_WIDTH-1:0]  dsr;
  logic [DIVISOR_WIDTH-1:0]  rem;
  logic                      sign_q;
  logic                      sign_r;

  logic [DIVIDEND_WIDTH-1:0] neg_dividend;
  logic [DIVISOR_WIDTH-1:0]  neg_divisor;
  logic [DIVIDEND_WIDTH-1:0] abs_dividend;
  logic [DIVISOR_WIDTH-1:0]  abs_divisor;

  logic [DIVISOR_WIDTH:0]    pr;
  logic                      take;
  logic [DIVISOR_WIDTH-1:0]  rem_next;
  logic [DIVIDEND_WIDTH-1:0] dvd_next;

  logic signed [QUOTIENT_WIDTH-1:0] sat_q;
  logic                             sat_ovf;

  // Two's complement negation of the most negative operand yields exactly
  // 2^(W-1), which is the correct magnitude when read as unsigned.
  assign neg_dividend = -dividend;
  assign neg_divisor  = -divisor;
  assign abs_dividend = dividend[DIVIDEND_WIDTH-1] ? neg_dividend : dividend;
  assign abs_divisor  = divisor[DIVISOR_WIDTH-1]   ? neg_divisor  : divisor;

  // The dividend register doubles as the quotient register: each step shifts
  // the next dividend bit out of the top and the new quotient bit into the
  // bottom. Because the partial remainder is always below |divisor|, the
  // subtraction result fits in the low DIVISOR_WIDTH bits.
  always_comb begin
    pr       = {rem, dvd[DIVIDEND_WIDTH-1]};
    take     = (pr >= {1'b0, dsr});
    rem_next = take ? (pr[DIVISOR_WIDTH-1:0] - dsr) : pr[DIVISOR_WIDTH-1:0];
    dvd_next = {dvd[DIVIDEND_WIDTH-2:0], take};
  end

  cnn_div_seq_23s_14s_sat u_sat (
    .mag (dvd_next),
    .neg (sign_q),
    .q   (sat_q),
    .ovf (sat_ovf)
  );

  // Control FSM and datapath registers. Results are registered on the final
  // iteration so they appear together with out_valid. in_ready is held low
  // on the cycle following a reset edge and otherwise tracks IDLE.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd       <= '0;
      dsr       <= '0;
      rem       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_ready && in_valid) begin
            dvd      <= abs_dividend;
            dsr      <= abs_divisor;
            rem      <= '0;
            sign_q   <= dividend[DIVIDEND_WIDTH-1] ^ divisor[DIVISOR_WIDTH-1];
            sign_r   <= dividend[DIVIDEND_WIDTH-1];
            in_ready <= 1'b0;
            if (divisor == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              dbz       <= 1'b1;
              ovf       <= 1'b0;
              remainder <= '0;
              if (dividend == '0)
                quotient <= '0;
              else if (dividend[DIVIDEND_WIDTH-1])
                quotient <= QMIN;
              else
                quotient <= QMAX;
            end else begin
              state <= CALC;
              cnt   <= CNT_INIT;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        CALC: begin
          rem <= rem_next;
          dvd <= dvd_next;
          cnt <= cnt - CNT_WIDTH'(1);
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= sat_q;
            ovf       <= sat_ovf;
            dbz       <= 1'b0;
            remainder <= sign_r ? -rem_next : rem_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_div_seq_23s_14s.sv
// Self-checking bench for cnn_div_seq_23s_14s: directed cases with literal
// expectations, backpressure and mid-calculation reset, then randomized
// operands, all tracked by a C-semantics reference model.
module tb_cnn_div_seq_23s_14s;

  logic              ap_clk = 1'b0;
  logic              ap_rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [22:0] dividend = '0;
  logic signed [13:0] divisor = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [8:0] quotient;
  logic signed [13:0] remainder;
  logic              ovf;
  logic              dbz;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int     dvd;
    int     dsr;
    longint acc;
  } txn_t;

  txn_t   pend[$];
  longint cyc = 0;
  bit     mon_en = 1'b0;
  bit     last_edge_rst = 1'b1;

  cnn_div_seq_23s_14s dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: C division truncating toward zero, then clip to 9-bit signed.
  function automatic void model(input int dvd, input int dsr, output int q,
                                output int r, output int eovf, output int edbz);
    int qq;
    if (dsr == 0) begin
      edbz = 1;
      eovf = 0;
      r    = 0;
      q    = (dvd > 0) ? 255 : ((dvd < 0) ? -256 : 0);
    end else begin
      qq   = dvd / dsr;
      r    = dvd % dsr;
      edbz = 0;
      eovf = 0;
      q    = qq;
      if (qq > 255) begin
        q = 255;
        eovf = 1;
      end else if (qq < -256) begin
        q = -256;
        eovf = 1;
      end
    end
  endfunction

  function automatic int latency(input int dsr);
    return (dsr == 0) ? 1 : 24;
  endfunction

  task automatic compare(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d want=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every-cycle monitor: handshake signals against the outstanding
  // transaction queue, and result fields against the model while valid.
  always @(negedge ap_clk) begin
    int eq, er, eovf, edbz;
    bit exp_valid;
    if (mon_en) begin
      compare("in_ready", int'(in_ready), int'(!last_edge_rst && pend.size() == 0));
      exp_valid = 1'b0;
      if (pend.size() > 0)
        exp_valid = (cyc - pend[0].acc + 1) >= latency(pend[0].dsr);
      compare("out_valid", int'(out_valid), int'(exp_valid));
      if (out_valid && pend.size() > 0) begin
        model(pend[0].dvd, pend[0].dsr, eq, er, eovf, edbz);
        compare("mon_quotient", int'(quotient), eq);
        compare("mon_remainder", int'(remainder), er);
        compare("mon_ovf", int'(ovf), eovf);
        compare("mon_dbz", int'(dbz), edbz);
      end
      if (ap_rst) begin
        pend.delete();
      end else begin
        if (out_valid && out_ready && pend.size() > 0) void'(pend.pop_front());
        if (in_valid && in_ready) pend.push_back('{int'(dividend), int'(divisor), cyc + 1});
      end
    end
    last_edge_rst = ap_rst;
  end

  // Presents operands until the DUT accepts them; entered and left at
  // posedge+1.
  task automatic applyStimulus(input int dvd, input int dsr);
    bit ok;
    dividend = 23'(dvd);
    divisor  = 14'(dsr);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge ap_clk);
      ok = in_ready;
      @(posedge ap_clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL accept_timeout got=no_accept want=accept");
    end
  endtask

  // Waits for a result, checks literal values, optionally stalls for 'hold'
  // cycles while pulsing in_valid, then completes the handshake.
  task automatic checkOutput(input string name, input int eq, input int er,
                             input int eovf, input int edbz, input int hold);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge ap_clk);
      seen = out_valid;
    end
    compare({name, "_seen"}, int'(seen), 1);
    compare({name, "_q"}, int'(quotient), eq);
    compare({name, "_r"}, int'(remainder), er);
    compare({name, "_ovf"}, int'(ovf), eovf);
    compare({name, "_dbz"}, int'(dbz), edbz);
    @(posedge ap_clk);
    #1;
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      dividend = 23'($urandom);
      divisor  = 14'($urandom);
      @(negedge ap_clk);
      compare({name, "_hold_ready"}, int'(in_ready), 0);
      compare({name, "_hold_q"}, int'(quotient), eq);
      @(posedge ap_clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    out_ready = 1'b0;
    @(negedge ap_clk);
    compare({name, "_ready_after"}, int'(in_ready), 1);
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    int q, r, o, z;
    int dvd, dsr, mode;
    bit hs;

    $display("[TB] start");

    model(1000, 7, q, r, o, z);
    compare("model_1000_7_q", q, 142);
    compare("model_1000_7_r", r, 6);
    model(-2048, 8, q, r, o, z);
    compare("model_m2048_8_q", q, -256);
    compare("model_m2048_8_ovf", o, 0);
    model(-5, 0, q, r, o, z);
    compare("model_m5_0_q", q, -256);
    compare("model_m5_0_dbz", z, 1);

    repeat (3) @(posedge ap_clk);
    #1;
    compare("rst_in_ready", int'(in_ready), 0);
    compare("rst_out_valid", int'(out_valid), 0);
    compare("rst_quotient", int'(quotient), 0);
    compare("rst_remainder", int'(remainder), 0);
    compare("rst_ovf", int'(ovf), 0);
    compare("rst_dbz", int'(dbz), 0);
    ap_rst = 1'b0;
    mon_en = 1'b1;
    @(posedge ap_clk);
    #1;
    compare("post_rst_in_ready", int'(in_ready), 1);

    applyStimulus(1000, 7);        checkOutput("d1000_7", 142, 6, 0, 0, 0);
    applyStimulus(-1000, 7);       checkOutput("dm1000_7", -142, -6, 0, 0, 0);
    applyStimulus(1000, -7);       checkOutput("d1000_m7", -142, 6, 0, 0, 0);
    applyStimulus(-2048, 8);       checkOutput("dm2048_8", -256, 0, 0, 0, 0);
    applyStimulus(100000, 3);      checkOutput("d100000_3", 255, 1, 1, 0, 0);
    applyStimulus(-4194304, -8192); checkOutput("dmin_mmin", 255, 0, 1, 0, 0);
    applyStimulus(4194303, -1);    checkOutput("dmax_m1", -256, 0, 1, 0, 0);
    applyStimulus(5, 0);           checkOutput("d5_0", 255, 0, 0, 1, 0);
    applyStimulus(-5, 0);          checkOutput("dm5_0", -256, 0, 0, 1, 0);
    applyStimulus(0, 0);           checkOutput("d0_0", 0, 0, 0, 1, 0);

    applyStimulus(1000, 7);        checkOutput("bp_1000_7", 142, 6, 0, 0, 10);

    applyStimulus(12345, 67);
    repeat (10) @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    compare("midrst_out_valid", int'(out_valid), 0);
    compare("midrst_in_ready", int'(in_ready), 0);
    repeat (30) @(posedge ap_clk);
    #1;
    applyStimulus(9, 2);           checkOutput("d9_2", 4, 1, 0, 0, 0);

    for (int t = 0; t < 300; t++) begin
      mode = $urandom_range(0, 4);
      case (mode)
        0: begin dvd = int'(23'($urandom)) - 4194304; dsr = $urandom_range(0, 16383) - 8192; end
        1: begin dvd = $urandom_range(0, 6000) - 3000; dsr = $urandom_range(0, 200) - 100; end
        2: begin dvd = $urandom_range(0, 40) - 20; dsr = $urandom_range(0, 10) - 5; end
        3: begin dvd = int'(23'($urandom)) - 4194304; dsr = 0; end
        default: begin
          dvd = ($urandom_range(0, 1) != 0) ? 4194303 : -4194304;
          dsr = ($urandom_range(0, 1) != 0) ? 8191 : -8192;
        end
      endcase
      applyStimulus(dvd, dsr);
      hs = 1'b0;
      for (int c = 0; c < 200 && !hs; c++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge ap_clk);
        hs = out_valid && out_ready;
        @(posedge ap_clk);
        #1;
      end
      out_ready = 1'b0;
      checks++;
      if (!hs) begin
        failures++;
        $display("[TB] FAIL rand_handshake got=none want=handshake (txn %0d)", t);
      end
    end

    repeat (3) @(posedge ap_clk);
    #1;
    compare("final_pending", pend.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
